branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Parametrised successor to the execute-stage branch comparator.
- Resolves conditional branches in EX, using the same BranchTypeE codes from Parameters.v: NOBRANCH, BEQ, BNE, BLT, BLTU, BGE, BGEU.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, giving a same-cycle prediction to IF.
- Adds misprediction detection with a redirect PC, and saturating performance counters.
- Sits between IF (PC selection) and EX (branch resolution) of the 5-stage pipeline. Hazard unit consumes MispredictE to flush IF/ID.

Parameters:
XLEN, 32, datapath and PC width
INDEX_W, 6, BTB index bits; 2**INDEX_W entries, indexed by PC[INDEX_W+1:2]
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
PCF  in  XLEN  fetch-stage PC
PredTakenF  out  1  fetch prediction: taken
PredTargetF  out  XLEN  predicted next PC
ResolveValidE  in  1  EX holds a valid, non-stalled, non-flushed instruction
BranchTypeE  in  3  branch type code from Parameters.v
Operand1E  in  XLEN  rs1 value (post-forwarding)
Operand2E  in  XLEN  rs2 value (post-forwarding)
PCE  in  XLEN  EX-stage PC
BranchTargetE  in  XLEN  computed branch target
PredTakenE  in  1  PredTakenF, piped to EX
PredTargetE  in  XLEN  PredTargetF, piped to EX
BranchE  out  1  branch resolved taken
MispredictE  out  1  redirect required
CorrectPCE  out  XLEN  redirect PC
BranchCnt  out  CNT_W  resolved conditional branches
MispredCnt  out  CNT_W  mispredictions

Behaviour:
- Entry fields: valid, tag = PC[XLEN-1:INDEX_W+2], target[XLEN-1:0], ctr[1:0].
- Prediction (combinational, no latency):
  - hit = valid[idxF] && tag[idxF] == tagF.
  - PredTakenF = hit && ctr[idxF][1].
  - PredTargetF = PredTakenF ? target[idxF] : PCF+4 (mod 2**XLEN).
- Resolution (combinational):
  - BranchE = condition per BranchTypeE. BLT/BGE are signed; BLTU/BGEU are unsigned.
  - BranchE = 0 for NOBRANCH, undefined codes, or ResolveValidE=0.
- MispredictE, only when ResolveValidE=1:
  - MispredictE = (BranchE != PredTakenE) || (BranchE && PredTargetE != BranchTargetE).
  - NOBRANCH/undefined code with PredTakenE=1 (stale alias) gives MispredictE=1.
  - ResolveValidE=0 forces MispredictE=0.
- CorrectPCE = BranchE ? BranchTargetE : PCE+4. Meaningful only when MispredictE=1.
- Update at posedge clk, only when ResolveValidE=1; hitE is the tag check at idxE = PCE[INDEX_W+1:2].
  - Conditional type, taken, miss: allocate entry. valid=1, tag, target=BranchTargetE, ctr=2'b10.
  - Conditional type, taken, hit: target=BranchTargetE, ctr saturating increment (max 2'b11).
  - Conditional type, not taken, hit: ctr saturating decrement (min 2'b00).
  - Conditional type, not taken, miss: no write.
  - NOBRANCH/undefined code with hitE: valid cleared.
- Performance counters:
  - BranchCnt +1 per resolution with a conditional type.
  - MispredCnt +1 per cycle with MispredictE=1.
  - Both saturate at all-ones (no wrap).
- Same-cycle read/write to the same index: the IF read returns the pre-update entry. No bypass.
- ResolveValidE=0 means no state change at all, including counters.
- Reset (async, any time, including mid-update):
  - all valid=0, all ctr=2'b01, BranchCnt=MispredCnt=0.
  - After reset: PredTakenF=0, PredTargetF=PCF+4. Combinational outputs follow their inputs.
- Storage in flops (reset required). No RAM inference.

Test Plan:
- Reset, PCF=0x100 -> PredTakenF=0, PredTargetF=0x104; BranchCnt=MispredCnt=0.
- BLT, Operand1E=0xFFFFFFFF, Operand2E=1, PCE=0x100, BranchTargetE=0x200, PredTakenE=0 -> BranchE=1, MispredictE=1, CorrectPCE=0x200. Next cycle, PCF=0x100 -> PredTakenF=1, PredTargetF=0x200; MispredCnt=1.
- BLTU with the same operands -> BranchE=0. On a hit entry (ctr=2'b10), ctr becomes 2'b01 -> next PCF=0x100 gives PredTakenF=0.
- Aliasing: PCE=0x100 allocated, then PCF=0x200 (same index, different tag) -> PredTakenF=0, PredTargetF=0x204.
- Training: four taken BEQ at 0x100 -> ctr=2'b11. One not-taken -> 2'b10, still predicts taken. ResolveValidE=0 cycle with BEQ -> no ctr or counter change.
- Counter saturation (CNT_W=4): 16 mispredictions -> MispredCnt=0xF. Assert rst_n low mid-cycle -> counters 0 and PredTakenF=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/branch_predict_unit.sv
// EX-stage branch resolution with a direct-mapped BTB (2-bit counters) feeding IF predictions.
// Latency: prediction and resolution are combinational; BTB and counter updates land on the next clk edge.
// Backpressure: none; ResolveValidE low (stall/flush/bubble) freezes all state.
module branch_predict_unit #(
    parameter int XLEN    = 32,
    parameter int INDEX_W = 6,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  PCF,
    output logic             PredTakenF,
    output logic [XLEN-1:0]  PredTargetF,
    input  logic             ResolveValidE,
    input  logic [2:0]       BranchTypeE,
    input  logic [XLEN-1:0]  Operand1E,
    input  logic [XLEN-1:0]  Operand2E,
    input  logic [XLEN-1:0]  PCE,
    input  logic [XLEN-1:0]  BranchTargetE,
    input  logic             PredTakenE,
    input  logic [XLEN-1:0]  PredTargetE,
    output logic             BranchE,
    output logic             MispredictE,
    output logic [XLEN-1:0]  CorrectPCE,
    output logic [CNT_W-1:0] BranchCnt,
    output logic [CNT_W-1:0] MispredCnt
);
    localparam int ENTRIES = 1 << INDEX_W;
    localparam int TAG_W   = XLEN - INDEX_W - 2;

    localparam logic [2:0] NOBRANCH = 3'd0;
    localparam logic [2:0] BEQ      = 3'd1;
    localparam logic [2:0] BNE      = 3'd2;
    localparam logic [2:0] BLT      = 3'd3;
    localparam logic [2:0] BLTU     = 3'd4;
    localparam logic [2:0] BGE      = 3'd5;
    localparam logic [2:0] BGEU     = 3'd6;

    logic             btb_vld [ENTRIES];
    logic [TAG_W-1:0] btb_tag [ENTRIES];
    logic [XLEN-1:0]  btb_tgt [ENTRIES];
    logic [1:0]       btb_ctr [ENTRIES];

    logic [INDEX_W-1:0] idx_f, idx_e;
    logic [TAG_W-1:0]   tag_f, tag_e;
    logic               hit_f, hit_e;
    logic               is_cond, cond_taken;
    logic               unused_pc_lsbs;

    assign idx_f = PCF[INDEX_W+1:2];
    assign tag_f = PCF[XLEN-1:INDEX_W+2];
    assign idx_e = PCE[INDEX_W+1:2];
    assign tag_e = PCE[XLEN-1:INDEX_W+2];
    assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

    assign hit_f       = btb_vld[idx_f] && (btb_tag[idx_f] == tag_f);
    assign hit_e       = btb_vld[idx_e] && (btb_tag[idx_e] == tag_e);
    assign PredTakenF  = hit_f && btb_ctr[idx_f][1];
    assign PredTargetF = PredTakenF ? btb_tgt[idx_f] : PCF + XLEN'(4);

    always_comb begin
        is_cond    = 1'b1;
        cond_taken = 1'b0;
        case (BranchTypeE)
            BEQ:     cond_taken = (Operand1E == Operand2E);
            BNE:     cond_taken = (Operand1E != Operand2E);
            BLT:     cond_taken = ($signed(Operand1E) <  $signed(Operand2E));
            BLTU:    cond_taken = (Operand1E <  Operand2E);
            BGE:     cond_taken = ($signed(Operand1E) >= $signed(Operand2E));
            BGEU:    cond_taken = (Operand1E >= Operand2E);
            default: is_cond    = 1'b0;
        endcase
    end

    assign BranchE     = ResolveValidE && cond_taken;
    // A predicted-taken non-branch (stale alias) also redirects, since BranchE is 0 there.
    assign MispredictE = ResolveValidE &&
                         ((BranchE != PredTakenE) || (BranchE && (PredTargetE != BranchTargetE)));
    assign CorrectPCE  = BranchE ? BranchTargetE : PCE + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_vld[i] <= 1'b0;
                btb_tag[i] <= '0;
                btb_tgt[i] <= '0;
                btb_ctr[i] <= 2'b01;
            end
        end else if (ResolveValidE) begin
            if (is_cond) begin
                if (BranchE) begin
                    btb_tgt[idx_e] <= BranchTargetE;
                    if (hit_e) begin
                        btb_ctr[idx_e] <= (btb_ctr[idx_e] == 2'b11) ? 2'b11 : btb_ctr[idx_e] + 2'd1;
                    end else begin
                        btb_vld[idx_e] <= 1'b1;
                        btb_tag[idx_e] <= tag_e;
                        btb_ctr[idx_e] <= 2'b10;
                    end
                end else if (hit_e) begin
                    btb_ctr[idx_e] <= (btb_ctr[idx_e] == 2'b00) ? 2'b00 : btb_ctr[idx_e] - 2'd1;
                end
            end else if (hit_e) begin
                btb_vld[idx_e] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BranchCnt  <= '0;
            MispredCnt <= '0;
        end else if (ResolveValidE) begin
            if (is_cond && (BranchCnt != '1))
                BranchCnt <= BranchCnt + CNT_W'(1);
            if (MispredictE && (MispredCnt != '1))
                MispredCnt <= MispredCnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: BTB allocate/train/alias/invalidate, resolution, counters, async reset.
module tb_branch_predict_unit;
    localparam int XLEN    = 32;
    localparam int INDEX_W = 6;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [XLEN-1:0]  PCF;
    logic             PredTakenF;
    logic [XLEN-1:0]  PredTargetF;
    logic             ResolveValidE;
    logic [2:0]       BranchTypeE;
    logic [XLEN-1:0]  Operand1E, Operand2E, PCE, BranchTargetE, PredTargetE;
    logic             PredTakenE;
    logic             BranchE, MispredictE;
    logic [XLEN-1:0]  CorrectPCE;
    logic [CNT_W-1:0] BranchCnt, MispredCnt;

    int n_cmp = 0;
    int n_err = 0;

    branch_predict_unit #(.XLEN(XLEN), .INDEX_W(INDEX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
        .ResolveValidE(ResolveValidE), .BranchTypeE(BranchTypeE), .Operand1E(Operand1E),
        .Operand2E(Operand2E), .PCE(PCE), .BranchTargetE(BranchTargetE), .PredTakenE(PredTakenE),
        .PredTargetE(PredTargetE), .BranchE(BranchE), .MispredictE(MispredictE),
        .CorrectPCE(CorrectPCE), .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic res(input logic v, input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] bt, input logic pt, input logic [31:0] ptg);
        ResolveValidE = v; BranchTypeE = t; Operand1E = a; Operand2E = b;
        PCE = pc; BranchTargetE = bt; PredTakenE = pt; PredTargetE = ptg;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        ResolveValidE = 1'b0;
        #1;
    endtask

    task automatic chk_pred(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        PCF = pc;
        #1;
        check({tag, "_taken"}, 64'(PredTakenF), 64'(tk));
        check({tag, "_tgt"}, 64'(PredTargetF), 64'(tgt));
    endtask

    task automatic chk_cnt(input string tag, input int b, input int m);
        check({tag, "_bcnt"}, 64'(BranchCnt), 64'(b));
        check({tag, "_mcnt"}, 64'(MispredCnt), 64'(m));
    endtask

    task automatic chk_res(input string tag, input logic br, input logic mp, input logic [31:0] cpc);
        check({tag, "_br"}, 64'(BranchE), 64'(br));
        check({tag, "_mp"}, 64'(MispredictE), 64'(mp));
        if (mp) check({tag, "_cpc"}, 64'(CorrectPCE), 64'(cpc));
    endtask

    initial begin
        rst_n = 1'b0; PCF = 32'h100;
        res(1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 0);
        #12;
        chk_pred("rst", 32'h100, 1'b0, 32'h104);
        chk_cnt("rst", 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // BLT signed: -1 < 1 -> taken, predicted not-taken
        res(1'b1, 3'd3, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h200, 1'b0, 32'h104);
        chk_res("blt", 1'b1, 1'b1, 32'h200);
        chk_pred("blt_nobypass", 32'h100, 1'b0, 32'h104);
        cyc();
        chk_pred("blt_alloc", 32'h100, 1'b1, 32'h200);
        chk_cnt("blt", 1, 1);
        chk_pred("alias", 32'h200, 1'b0, 32'h204);

        // BLTU unsigned: 0xFFFFFFFF < 1 false; ctr 10 -> 01
        res(1'b1, 3'd4, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h200, 1'b1, 32'h200);
        chk_res("bltu", 1'b0, 1'b1, 32'h104);
        cyc();
        chk_pred("bltu_dec", 32'h100, 1'b0, 32'h104);
        chk_cnt("bltu", 2, 2);

        // Four taken BEQ: ctr 01->10->11->11; the last one is predicted correctly
        for (int i = 0; i < 3; i++) begin
            res(1'b1, 3'd1, 32'h5, 32'h5, 32'h100, 32'h300, 1'b0, 32'h104);
            chk_res("beq_t", 1'b1, 1'b1, 32'h300);
            cyc();
        end
        res(1'b1, 3'd1, 32'h5, 32'h5, 32'h100, 32'h300, 1'b1, 32'h300);
        chk_res("beq_ok", 1'b1, 1'b0, 32'h300);
        cyc();
        chk_pred("train", 32'h100, 1'b1, 32'h300);
        chk_cnt("train", 6, 5);

        res(1'b1, 3'd1, 32'h5, 32'h6, 32'h100, 32'h300, 1'b1, 32'h300);
        chk_res("beq_nt1", 1'b0, 1'b1, 32'h104);
        cyc();
        chk_pred("nt1", 32'h100, 1'b1, 32'h300);
        chk_cnt("nt1", 7, 6);

        // Invalid cycle must leave ctr (10) and counters untouched
        res(1'b0, 3'd1, 32'h5, 32'h5, 32'h100, 32'h300, 1'b0, 32'h104);
        chk_res("inval", 1'b0, 1'b0, 32'h0);
        @(posedge clk); #2;
        chk_cnt("inval", 7, 6);

        res(1'b1, 3'd1, 32'h5, 32'h6, 32'h100, 32'h300, 1'b1, 32'h300);
        chk_res("beq_nt2", 1'b0, 1'b1, 32'h104);
        cyc();
        chk_pred("nt2", 32'h100, 1'b0, 32'h104);
        chk_cnt("nt2", 8, 7);

        // BGE signed: 1 >= -1 taken, allocate at 0x140
        res(1'b1, 3'd5, 32'h1, 32'hFFFF_FFFF, 32'h140, 32'h400, 1'b0, 32'h144);
        chk_res("bge", 1'b1, 1'b1, 32'h400);
        cyc();
        chk_pred("bge_alloc", 32'h140, 1'b1, 32'h400);
        chk_cnt("bge", 9, 8);

        // Undefined code on a predicted-taken hit: redirect to PC+4 and invalidate
        res(1'b1, 3'd7, 32'h1, 32'h1, 32'h140, 32'h400, 1'b1, 32'h400);
        chk_res("undef", 1'b0, 1'b1, 32'h144);
        cyc();
        chk_pred("undef_inv", 32'h140, 1'b0, 32'h144);
        chk_cnt("undef", 9, 9);

        // Taken with wrong predicted target
        res(1'b1, 3'd2, 32'h1, 32'h2, 32'h140, 32'h600, 1'b1, 32'h500);
        chk_res("bne_tgt", 1'b1, 1'b1, 32'h600);
        cyc();
        chk_cnt("bne_tgt", 10, 10);

        for (int i = 0; i < 8; i++) begin
            res(1'b1, 3'd2, 32'h1, 32'h2, 32'h140, 32'h600, 1'b0, 32'h144);
            cyc();
        end
        chk_cnt("sat", 15, 15);
        chk_pred("sat", 32'h140, 1'b1, 32'h600);

        // Async reset between edges
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_cnt("arst", 0, 0);
        chk_pred("arst", 32'h140, 1'b0, 32'h144);
        chk_pred("arst_b", 32'h100, 1'b0, 32'h104);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
